// File: rtl/sprite_blitter_if.sv
// Pixel-pipeline bundle between VGA timing/sprite ROM (master) and sprite_blitter (slave).
// Carries the optional mirror control when SPRITE_BLITTER_MIRROR_EN is defined.
// No handshake: every signal is sampled or driven once per pixel clock.
interface sprite_blitter_if #(
    parameter int ADDR_W = 11,
    parameter int IDX_W  = 6
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              pos_wr;
    logic              anim_en;
`ifdef SPRITE_BLITTER_MIRROR_EN
    logic              mirror;
`endif
    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pix_idx;
    logic              pix_hit;
    logic              blank_d;

`ifdef SPRITE_BLITTER_MIRROR_EN
    modport master (
        output DrawX, DrawY, blank, pos_x, pos_y, pos_wr, anim_en, mirror, rom_q,
        input  rom_addr, pix_idx, pix_hit, blank_d
    );
    modport slave (
        input  DrawX, DrawY, blank, pos_x, pos_y, pos_wr, anim_en, mirror, rom_q,
        output rom_addr, pix_idx, pix_hit, blank_d
    );
`else
    modport master (
        output DrawX, DrawY, blank, pos_x, pos_y, pos_wr, anim_en, rom_q,
        input  rom_addr, pix_idx, pix_hit, blank_d
    );
    modport slave (
        input  DrawX, DrawY, blank, pos_x, pos_y, pos_wr, anim_en, rom_q,
        output rom_addr, pix_idx, pix_hit, blank_d
    );
`endif
endinterface

// File: rtl/sprite_blitter.sv
// Positioned, power-of-two scaled, animated sprite layer; optional horizontal flip via SPRITE_BLITTER_MIRROR_EN.
// Latency: fixed 3 vga_clk cycles from DrawX/DrawY to pix_idx/pix_hit/blank_d.
// Backpressure: none; the pipeline advances every cycle and never stalls.
module sprite_blitter #(
    parameter int SPR_W           = 16,
    parameter int SPR_H           = 16,
    parameter int NUM_FRAMES      = 4,
    parameter int SCALE_SHIFT     = 1,
    parameter int ADDR_W          = 11,
    parameter int IDX_W           = 6,
    parameter int TRANSPARENT_IDX = 0,
    parameter int ANIM_DIV        = 8,
    parameter int COMMIT_LINE     = 480
) (
    input logic           vga_clk,
    input logic           reset_n,
    sprite_blitter_if.slave bus
);
    localparam int FRAME_SZ = SPR_W * SPR_H;
    localparam int W_LIM    = SPR_W << SCALE_SHIFT;
    localparam int H_LIM    = SPR_H << SCALE_SHIFT;
    localparam int FRM_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    // Position and animation state
    logic [9:0]       shadow_x_q, shadow_y_q;
    logic [9:0]       act_x_q, act_y_q;
    logic [FRM_W-1:0] frame_q;
    logic [DIV_W-1:0] div_q;
    logic             commit;

    // Pipeline state
    logic [10:0]       dx, dy;
    logic [9:0]        lx_raw, ly;
    logic [31:0]       lx_w;
    logic              s0_hit_d;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic              hit_q, blank_q;
    logic              hit_dd_q, blank_dd_q;
    logic              pix_hit_d, pix_hit_q;
    logic [IDX_W-1:0]  pix_idx_d, pix_idx_q;
    logic              blank_d_q;

`ifdef SPRITE_BLITTER_MIRROR_EN
    logic mirror_q;
`endif

    assign commit = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(COMMIT_LINE));

    // Active position only changes during vertical blank, so the visible frame never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            frame_q    <= '0;
            div_q      <= '0;
        end else begin
            if (bus.pos_wr) begin
                shadow_x_q <= bus.pos_x;
                shadow_y_q <= bus.pos_y;
            end
            if (commit) begin
                act_x_q <= shadow_x_q;
                act_y_q <= shadow_y_q;
                if (bus.anim_en) begin
                    if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                        div_q   <= '0;
                        frame_q <= (frame_q == FRM_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
            end
        end
    end

`ifdef SPRITE_BLITTER_MIRROR_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            mirror_q <= 1'b0;
        end else if (commit) begin
            mirror_q <= bus.mirror;
        end
    end
`endif

    // Stage 0: sprite-relative offset; bit 10 of dx/dy flags a pixel left of / above the sprite.
    always_comb begin
        dx       = {1'b0, bus.DrawX} - {1'b0, act_x_q};
        dy       = {1'b0, bus.DrawY} - {1'b0, act_y_q};
        lx_raw   = dx[9:0] >> SCALE_SHIFT;
        ly       = dy[9:0] >> SCALE_SHIFT;
        s0_hit_d = ~dx[10] && ~dy[10]
                && (32'(dx[9:0]) < 32'(W_LIM))
                && (32'(dy[9:0]) < 32'(H_LIM));
`ifdef SPRITE_BLITTER_MIRROR_EN
        lx_w = mirror_q ? (32'(SPR_W - 1) - 32'(lx_raw)) : 32'(lx_raw);
`else
        lx_w = 32'(lx_raw);
`endif
        rom_addr_d = rom_addr_q;
        if (s0_hit_d) begin
            rom_addr_d = ADDR_W'(32'(frame_q) * 32'(FRAME_SZ) + 32'(ly) * 32'(SPR_W) + lx_w);
        end
    end

    // Stage 2: opacity test on the ROM word that arrived this cycle.
    always_comb begin
        pix_hit_d = hit_dd_q && blank_dd_q && (bus.rom_q != IDX_W'(TRANSPARENT_IDX));
        pix_idx_d = pix_hit_d ? bus.rom_q : '0;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            hit_q      <= 1'b0;
            blank_q    <= 1'b0;
            hit_dd_q   <= 1'b0;
            blank_dd_q <= 1'b0;
            pix_hit_q  <= 1'b0;
            pix_idx_q  <= '0;
            blank_d_q  <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit_q      <= s0_hit_d;
            blank_q    <= bus.blank;
            hit_dd_q   <= hit_q;
            blank_dd_q <= blank_q;
            pix_hit_q  <= pix_hit_d;
            pix_idx_q  <= pix_idx_d;
            blank_d_q  <= blank_dd_q;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.pix_hit  = pix_hit_q;
    assign bus.pix_idx  = pix_idx_q;
    assign bus.blank_d  = blank_d_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: 2x scaled 16x16 sprite, 4 frames, ROM word = (addr*5) mod 64.
module tb_sprite_blitter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    sprite_blitter_if #(.ADDR_W(11), .IDX_W(6)) bus ();

    sprite_blitter dut (
        .vga_clk (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] rom_val(input logic [10:0] a);
        return 6'(a * 11'd5);
    endfunction

    always @(posedge clk) bus.rom_q <= rom_val(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.DrawX = 10'd1023;
        bus.DrawY = 10'd1023;
        bus.blank = 1'b0;
    endtask

    // One pixel for one cycle, then idle; address checked after 1 edge, outputs after exactly 3.
    task automatic probe(input string tag, input int x, input int y, input logic b,
                         input int e_addr, input logic e_hit, input int e_idx);
        @(negedge clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = b;
        @(posedge clk); #1;
        check({tag, ".addr"}, 32'(bus.rom_addr), 32'(e_addr));
        @(negedge clk);
        idle();
        @(posedge clk);
        @(posedge clk); #1;
        check({tag, ".hit"}, 32'(bus.pix_hit), 32'(e_hit));
        check({tag, ".idx"}, 32'(bus.pix_idx), 32'(e_idx));
        check({tag, ".blank_d"}, 32'(bus.blank_d), 32'(b));
    endtask

    task automatic write_pos(input int x, input int y);
        @(negedge clk);
        bus.pos_x  = 10'(x);
        bus.pos_y  = 10'(y);
        bus.pos_wr = 1'b1;
        @(negedge clk);
        bus.pos_wr = 1'b0;
    endtask

    task automatic commit(input logic wr, input int x, input int y);
        @(negedge clk);
        bus.DrawX  = 10'd0;
        bus.DrawY  = 10'd480;
        bus.blank  = 1'b0;
        bus.pos_wr = wr;
        bus.pos_x  = 10'(x);
        bus.pos_y  = 10'(y);
        @(negedge clk);
        bus.pos_wr = 1'b0;
        idle();
    endtask

    task automatic commits(input int n);
        for (int i = 0; i < n; i++) commit(1'b0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle();
        bus.pos_x   = '0;
        bus.pos_y   = '0;
        bus.pos_wr  = 1'b0;
        bus.anim_en = 1'b0;
`ifdef SPRITE_BLITTER_MIRROR_EN
        bus.mirror  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst.addr", 32'(bus.rom_addr), 0);
        check("rst.hit", 32'(bus.pix_hit), 0);
        check("rst.idx", 32'(bus.pix_idx), 0);
        check("rst.blank_d", 32'(bus.blank_d), 0);
        @(negedge clk);
        rst_n = 1'b1;

        write_pos(100, 50);
        commit(1'b0, 0, 0);
        probe("x99", 99, 50, 1'b1, 0, 1'b0, 0);
        probe("x100", 100, 50, 1'b1, 0, 1'b0, 0);
        probe("x101", 101, 50, 1'b1, 0, 1'b0, 0);
        probe("x102", 102, 50, 1'b1, 1, 1'b1, 5);
        probe("x131", 131, 50, 1'b1, 15, 1'b1, 11);
        probe("x132", 132, 50, 1'b1, 15, 1'b0, 0);
        probe("mid", 110, 61, 1'b1, 85, 1'b1, 41);
        probe("ybot", 100, 81, 1'b1, 240, 1'b1, 48);
        probe("ypast", 100, 82, 1'b1, 240, 1'b0, 0);
        probe("yabove", 100, 49, 1'b1, 240, 1'b0, 0);
        probe("blank0", 102, 50, 1'b0, 1, 1'b0, 0);

        // Mid-frame write must not move the sprite before the commit line.
        write_pos(300, 200);
        probe("tear.old", 102, 50, 1'b1, 1, 1'b1, 5);
        probe("tear.new", 310, 210, 1'b1, 1, 1'b0, 0);
        commit(1'b0, 0, 0);
        probe("moved.new", 310, 210, 1'b1, 85, 1'b1, 41);
        probe("moved.old", 102, 50, 1'b1, 85, 1'b0, 0);

        // Write in the commit cycle lands in shadow only.
        write_pos(630, 100);
        commit(1'b1, 500, 300);
        probe("edge.x630", 630, 100, 1'b1, 0, 1'b0, 0);
        probe("edge.x639", 639, 100, 1'b1, 4, 1'b1, 20);
        probe("nowrap.x21", 21, 100, 1'b1, 4, 1'b0, 0);
        probe("nowrap.x0", 0, 100, 1'b1, 4, 1'b0, 0);
        probe("cwr.pending", 500, 300, 1'b1, 4, 1'b0, 0);
        commit(1'b0, 0, 0);
        probe("cwr.applied", 502, 300, 1'b1, 1, 1'b1, 5);

        bus.anim_en = 1'b1;
        commits(7);
        probe("anim.7", 502, 300, 1'b1, 1, 1'b1, 5);
        commits(1);
        probe("anim.8", 502, 300, 1'b1, 257, 1'b1, 5);
        commits(24);
        probe("anim.32", 502, 300, 1'b1, 1, 1'b1, 5);
        bus.anim_en = 1'b0;
        commits(8);
        probe("anim.hold0", 502, 300, 1'b1, 1, 1'b1, 5);
        bus.anim_en = 1'b1;
        commits(8);
        bus.anim_en = 1'b0;
        commits(16);
        probe("anim.hold1", 502, 300, 1'b1, 257, 1'b1, 5);
        bus.anim_en = 1'b1;
        commits(16);
        probe("anim.f3", 502, 300, 1'b1, 769, 1'b1, 5);
        commits(8);
        probe("anim.wrap", 502, 300, 1'b1, 1, 1'b1, 5);
        bus.anim_en = 1'b0;

        // Asynchronous reset during active video.
        @(negedge clk);
        bus.DrawX = 10'd502;
        bus.DrawY = 10'd300;
        bus.blank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("prerst.hit", 32'(bus.pix_hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.addr", 32'(bus.rom_addr), 0);
        check("arst.hit", 32'(bus.pix_hit), 0);
        check("arst.idx", 32'(bus.pix_idx), 0);
        check("arst.blank_d", 32'(bus.blank_d), 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        probe("postrst", 3, 0, 1'b1, 1, 1'b1, 5);

`ifdef SPRITE_BLITTER_MIRROR_EN
        write_pos(100, 50);
        bus.mirror = 1'b1;
        commit(1'b0, 0, 0);
        probe("mir.x100", 100, 50, 1'b1, 15, 1'b1, 11);
        probe("mir.x131", 131, 50, 1'b1, 0, 1'b0, 0);
        bus.mirror = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
